// File: rtl/inst_fetcher.sv
// Instruction fetcher: single-cycle icache hits, 4-byte serial refill from a byte-wide
// memory arbiter on a miss, with the refilled word written back to the icache.
//
// state | meaning
// IDLE  | accept requests; hits are delivered the following cycle
// FETCH | issuing byte reads and collecting returned bytes
// DONE  | one-cycle cache fill and delivery of the refilled word
module inst_fetcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_req_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [31:0] rpc_o,
    input  logic        cache_hit_i,
    input  logic [31:0] cache_inst_i,
    output logic        cache_we_o,
    output logic [31:0] cache_wpc_o,
    output logic [31:0] cache_winst_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_data_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] base;
    logic [31:0] buffer;
    logic [31:0] hit_inst;
    logic [31:0] hit_pc;
    logic [1:0]  issue_cnt;
    logic [1:0]  recv_cnt;
    logic        issue_done;
    logic        pending;
    logic        hit_q;

    logic hit_start;
    logic miss_start;
    logic issue_req;
    logic grant;
    logic capture;
    logic last_byte;

    assign hit_start  = (state == ST_IDLE) && fetch_req_i && !flush_i && cache_hit_i;
    assign miss_start = (state == ST_IDLE) && fetch_req_i && !flush_i && !cache_hit_i;
    assign issue_req  = (state == ST_FETCH) && !issue_done && !flush_i;
    assign grant      = rdy && issue_req && mem_gnt_i;
    // pending marks that the byte granted last active cycle is on mem_data_i now
    assign capture    = rdy && (state == ST_FETCH) && !flush_i && pending;
    assign last_byte  = capture && (recv_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (miss_start) begin
                        state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (flush_i) begin
                        state_nxt = ST_IDLE;
                    end else if (last_byte) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rpc_o         = pc_i;
        mem_req_o     = rdy && issue_req;
        mem_addr_o    = base + {30'd0, issue_cnt};
        cache_we_o    = rdy && (state == ST_DONE);
        cache_wpc_o   = base;
        cache_winst_o = buffer;
        inst_valid_o  = rdy && (hit_q || (state == ST_DONE));
        inst_o        = (state == ST_DONE) ? buffer : hit_inst;
        inst_pc_o     = (state == ST_DONE) ? base : hit_pc;
        busy_o        = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base       <= '0;
            buffer     <= '0;
            hit_inst   <= '0;
            hit_pc     <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            issue_done <= 1'b0;
            pending    <= 1'b0;
            hit_q      <= 1'b0;
        end else if (rdy) begin
            hit_q <= hit_start;
            if (hit_start) begin
                hit_inst <= cache_inst_i;
                hit_pc   <= pc_i;
            end
            if (miss_start) begin
                base       <= pc_i;
                issue_cnt  <= '0;
                recv_cnt   <= '0;
                issue_done <= 1'b0;
                pending    <= 1'b0;
            end else if (state == ST_FETCH) begin
                if (flush_i) begin
                    pending <= 1'b0;
                end else begin
                    pending <= grant;
                    if (grant) begin
                        issue_cnt <= issue_cnt + 2'd1;
                        if (issue_cnt == 2'd3) begin
                            issue_done <= 1'b1;
                        end
                    end
                    if (capture) begin
                        buffer[{recv_cnt, 3'b000} +: 8] <= mem_data_i;
                        recv_cnt <= recv_cnt + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: hits, refills, grant stalls, flush, rdy freeze,
// address wrap and asynchronous reset, with hand-computed expectations.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        fetch_req_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic [31:0] rpc_o;
    logic        cache_hit_i;
    logic [31:0] cache_inst_i;
    logic        cache_we_o;
    logic [31:0] cache_wpc_o;
    logic [31:0] cache_winst_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic [7:0]  mem_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    inst_fetcher dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .fetch_req_i  (fetch_req_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .rpc_o        (rpc_o),
        .cache_hit_i  (cache_hit_i),
        .cache_inst_i (cache_inst_i),
        .cache_we_o   (cache_we_o),
        .cache_wpc_o  (cache_wpc_o),
        .cache_winst_o(cache_winst_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_data_i   (mem_data_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // IDLE-cycle miss request at pc; leaves the bench one cycle later (T+1)
    task automatic start(input string tag, input logic [31:0] pc);
        fetch_req_i = 1'b1;
        pc_i        = pc;
        cache_hit_i = 1'b0;
        mem_gnt_i   = 1'b0;
        #1;
        chk1({tag, ".req_idle"}, mem_req_o, 1'b0);
        nxt();
        fetch_req_i = 1'b0;
    endtask

    // one FETCH cycle: drive grant/data, check request and (if requesting) the address
    task automatic mcyc(input string tag, input logic g, input logic [7:0] d,
                        input logic er, input logic [31:0] ea);
        mem_gnt_i  = g;
        mem_data_i = d;
        #1;
        chk1({tag, ".req"}, mem_req_o, er);
        if (er) chk({tag, ".addr"}, mem_addr_o, ea);
        chk1({tag, ".we"}, cache_we_o, 1'b0);
        chk1({tag, ".busy"}, busy_o, 1'b1);
        nxt();
    endtask

    // DONE cycle followed by the IDLE cycle after it
    task automatic done_chk(input string tag, input logic [31:0] pc, input logic [31:0] word);
        mem_gnt_i  = 1'b0;
        mem_data_i = 8'h00;
        #1;
        chk1({tag, ".done_we"}, cache_we_o, 1'b1);
        chk({tag, ".done_wpc"}, cache_wpc_o, pc);
        chk({tag, ".done_winst"}, cache_winst_o, word);
        chk1({tag, ".done_valid"}, inst_valid_o, 1'b1);
        chk({tag, ".done_inst"}, inst_o, word);
        chk({tag, ".done_pc"}, inst_pc_o, pc);
        nxt();
        #1;
        chk1({tag, ".post_valid"}, inst_valid_o, 1'b0);
        chk1({tag, ".post_we"}, cache_we_o, 1'b0);
        chk1({tag, ".post_busy"}, busy_o, 1'b0);
        nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        rdy          = 1'b1;
        fetch_req_i  = 1'b0;
        pc_i         = 32'h0;
        flush_i      = 1'b0;
        cache_hit_i  = 1'b0;
        cache_inst_i = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_data_i   = 8'h00;

        #2;
        chk1("rst.busy", busy_o, 1'b0);
        chk1("rst.valid", inst_valid_o, 1'b0);
        chk1("rst.we", cache_we_o, 1'b0);
        chk1("rst.req", mem_req_o, 1'b0);
        chk("rst.inst", inst_o, 32'h0);
        chk("rst.wpc", cache_wpc_o, 32'h0);
        chk("rst.winst", cache_winst_o, 32'h0);
        nxt();
        rst = 1'b1;
        nxt();

        // single hit
        fetch_req_i  = 1'b1;
        pc_i         = 32'h100;
        cache_hit_i  = 1'b1;
        cache_inst_i = 32'h0000_0013;
        #1;
        chk("hit.rpc", rpc_o, 32'h100);
        chk1("hit.req_t", mem_req_o, 1'b0);
        nxt();
        fetch_req_i = 1'b0;
        cache_hit_i = 1'b0;
        #1;
        chk1("hit.valid", inst_valid_o, 1'b1);
        chk("hit.inst", inst_o, 32'h0000_0013);
        chk("hit.pc", inst_pc_o, 32'h100);
        chk1("hit.req", mem_req_o, 1'b0);
        chk1("hit.busy", busy_o, 1'b0);
        nxt();

        // back-to-back hits
        fetch_req_i  = 1'b1;
        cache_hit_i  = 1'b1;
        pc_i         = 32'h104;
        cache_inst_i = 32'hAAAA_0001;
        nxt();
        pc_i         = 32'h108;
        cache_inst_i = 32'hBBBB_0002;
        #1;
        chk("b2b.inst0", inst_o, 32'hAAAA_0001);
        chk("b2b.pc0", inst_pc_o, 32'h104);
        nxt();
        fetch_req_i = 1'b0;
        cache_hit_i = 1'b0;
        #1;
        chk1("b2b.valid1", inst_valid_o, 1'b1);
        chk("b2b.inst1", inst_o, 32'hBBBB_0002);
        chk("b2b.pc1", inst_pc_o, 32'h108);
        nxt();
        #1;
        chk1("b2b.valid_end", inst_valid_o, 1'b0);
        nxt();

        // miss with continuous grants
        start("miss", 32'h200);
        mcyc("miss.t1", 1'b1, 8'h00, 1'b1, 32'h200);
        mcyc("miss.t2", 1'b1, 8'h93, 1'b1, 32'h201);
        mcyc("miss.t3", 1'b1, 8'h00, 1'b1, 32'h202);
        mcyc("miss.t4", 1'b1, 8'h10, 1'b1, 32'h203);
        mcyc("miss.t5", 1'b0, 8'h00, 1'b0, 32'h0);
        done_chk("miss", 32'h200, 32'h0010_0093);

        // grant stalls on the first two cycles
        start("stall", 32'h300);
        mcyc("stall.t1", 1'b0, 8'h00, 1'b1, 32'h300);
        mcyc("stall.t2", 1'b0, 8'h00, 1'b1, 32'h300);
        mcyc("stall.t3", 1'b1, 8'h00, 1'b1, 32'h300);
        mcyc("stall.t4", 1'b1, 8'h11, 1'b1, 32'h301);
        mcyc("stall.t5", 1'b1, 8'h22, 1'b1, 32'h302);
        mcyc("stall.t6", 1'b1, 8'h33, 1'b1, 32'h303);
        mcyc("stall.t7", 1'b0, 8'h44, 1'b0, 32'h0);
        done_chk("stall", 32'h300, 32'h4433_2211);

        // flush after two bytes received, then a normal hit
        start("flush", 32'h500);
        mcyc("flush.t1", 1'b1, 8'h00, 1'b1, 32'h500);
        mcyc("flush.t2", 1'b1, 8'hAA, 1'b1, 32'h501);
        mcyc("flush.t3", 1'b1, 8'hBB, 1'b1, 32'h502);
        flush_i    = 1'b1;
        mem_gnt_i  = 1'b1;
        mem_data_i = 8'hCC;
        #1;
        chk1("flush.req", mem_req_o, 1'b0);
        chk1("flush.valid", inst_valid_o, 1'b0);
        chk1("flush.we", cache_we_o, 1'b0);
        nxt();
        flush_i      = 1'b0;
        mem_gnt_i    = 1'b0;
        fetch_req_i  = 1'b1;
        pc_i         = 32'h400;
        cache_hit_i  = 1'b1;
        cache_inst_i = 32'hDEAD_BEEF;
        #1;
        chk1("flush.idle_busy", busy_o, 1'b0);
        chk1("flush.idle_valid", inst_valid_o, 1'b0);
        chk1("flush.idle_we", cache_we_o, 1'b0);
        nxt();
        fetch_req_i = 1'b0;
        cache_hit_i = 1'b0;
        #1;
        chk1("flush.hit_valid", inst_valid_o, 1'b1);
        chk("flush.hit_inst", inst_o, 32'hDEAD_BEEF);
        chk("flush.hit_pc", inst_pc_o, 32'h400);
        nxt();
        #1;
        chk1("flush.hit_end", inst_valid_o, 1'b0);
        nxt();

        // flush beats a hit and a miss request in IDLE
        fetch_req_i = 1'b1;
        flush_i     = 1'b1;
        cache_hit_i = 1'b1;
        pc_i        = 32'h900;
        nxt();
        cache_hit_i = 1'b0;
        #1;
        chk1("fprio.hit_valid", inst_valid_o, 1'b0);
        nxt();
        fetch_req_i = 1'b0;
        flush_i     = 1'b0;
        #1;
        chk1("fprio.miss_busy", busy_o, 1'b0);
        nxt();

        // rdy low for three cycles mid-miss
        start("rdy", 32'h600);
        mcyc("rdy.t1", 1'b1, 8'h00, 1'b1, 32'h600);
        mcyc("rdy.t2", 1'b1, 8'h01, 1'b1, 32'h601);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_gnt_i  = 1'b1;
            mem_data_i = 8'hFF;
            #1;
            chk1("rdy.frz_req", mem_req_o, 1'b0);
            chk1("rdy.frz_busy", busy_o, 1'b1);
            chk1("rdy.frz_valid", inst_valid_o, 1'b0);
            chk("rdy.frz_addr", mem_addr_o, 32'h602);
            nxt();
        end
        rdy = 1'b1;
        mcyc("rdy.t6", 1'b1, 8'h02, 1'b1, 32'h602);
        mcyc("rdy.t7", 1'b1, 8'h03, 1'b1, 32'h603);
        mcyc("rdy.t8", 1'b0, 8'h04, 1'b0, 32'h0);
        done_chk("rdy", 32'h600, 32'h0403_0201);

        // address wraps past 2^32 on a misaligned base
        start("wrap", 32'hFFFF_FFFE);
        mcyc("wrap.t1", 1'b1, 8'h00, 1'b1, 32'hFFFF_FFFE);
        mcyc("wrap.t2", 1'b1, 8'hEF, 1'b1, 32'hFFFF_FFFF);
        mcyc("wrap.t3", 1'b1, 8'hBE, 1'b1, 32'h0000_0000);
        mcyc("wrap.t4", 1'b1, 8'hAD, 1'b1, 32'h0000_0001);
        mcyc("wrap.t5", 1'b0, 8'hDE, 1'b0, 32'h0);
        done_chk("wrap", 32'hFFFF_FFFE, 32'hDEAD_BEEF);

        // asynchronous reset mid-fetch
        start("arst", 32'h700);
        mcyc("arst.t1", 1'b1, 8'h00, 1'b1, 32'h700);
        mcyc("arst.t2", 1'b1, 8'h55, 1'b1, 32'h701);
        mem_gnt_i  = 1'b1;
        mem_data_i = 8'h66;
        #1;
        rst = 1'b0;
        #1;
        chk1("arst.req", mem_req_o, 1'b0);
        chk1("arst.busy", busy_o, 1'b0);
        chk1("arst.valid", inst_valid_o, 1'b0);
        chk1("arst.we", cache_we_o, 1'b0);
        chk("arst.addr", mem_addr_o, 32'h0);
        chk("arst.wpc", cache_wpc_o, 32'h0);
        chk("arst.winst", cache_winst_o, 32'h0);
        chk("arst.inst_pc", inst_pc_o, 32'h0);
        nxt();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_gnt_i  = 1'b1;
            mem_data_i = 8'h77;
            #1;
            chk1("arst.after_we", cache_we_o, 1'b0);
            chk1("arst.after_busy", busy_o, 1'b0);
            chk1("arst.after_valid", inst_valid_o, 1'b0);
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 rdy  in  1  global ready; 0 = freeze.
REQ-004 fetch_req_i  in  1  IF requests the instruction at pc_i.
REQ-005 pc_i  in  32  requested instruction address.
REQ-006 flush_i  in  1  branch redirect; abandon the current fetch.
REQ-007 rpc_o  out  32  icache lookup address.
REQ-008 cache_hit_i  in  1  icache hit for rpc_o, combinational.
REQ-009 cache_inst_i  in  32  icache data for rpc_o, combinational.
REQ-010 cache_we_o  out  1  icache fill strobe.
REQ-011 cache_wpc_o  out  32  fill address.
REQ-012 cache_winst_o  out  32  fill instruction.
REQ-013 mem_req_o  out  1  byte-read request to the memory arbiter.
REQ-014 mem_addr_o  out  32  byte address.
REQ-015 mem_gnt_i  in  1  arbiter accepts mem_addr_o this cycle.
REQ-016 mem_data_i  in  8  returned byte; valid in the first rdy=1 cycle after the grant cycle.
REQ-017 inst_valid_o  out  1  one-cycle pulse; instruction delivered.
REQ-018 inst_o  out  32  delivered instruction.
REQ-019 inst_pc_o  out  32  address of inst_o.
REQ-020 busy_o  out  1  high in FETCH and DONE.

Function
REQ-021 States: IDLE, FETCH, DONE.
REQ-022 rpc_o = pc_i at all times.
REQ-023 IDLE, fetch_req_i=1, flush_i=0, cache_hit_i=1:
  - next cycle inst_valid_o=1, inst_o=cache_inst_i, inst_pc_o=pc_i;
  - state stays IDLE; back-to-back hits every cycle.
REQ-024 IDLE, fetch_req_i=1, flush_i=0, cache_hit_i=0:
  - latch base=pc_i;
  - clear issue_cnt and recv_cnt (2-bit counters each, plus a done flag);
  - go to FETCH.
REQ-025 FETCH issue:
  - mem_req_o=1 while fewer than 4 bytes are issued;
  - mem_addr_o = base + issue_cnt (32-bit wrap);
  - issue_cnt increments only on mem_gnt_i=1;
  - without a grant, the same address is held.
REQ-026 FETCH receive:
  - a byte returns the cycle after each grant;
  - byte k goes into buffer bits [8k+7:8k] (little-endian);
  - issue of byte k+1 overlaps receipt of byte k.
REQ-027 When the 4th byte is captured, go to DONE.
REQ-028 DONE lasts exactly one cycle, with:
  - cache_we_o=1, cache_wpc_o=base, cache_winst_o=buffer;
  - inst_valid_o=1, inst_o=buffer, inst_pc_o=base.
  The next state is IDLE. fetch_req_i is ignored in DONE.
REQ-029 Miss latency with continuous grants:
  - request cycle T;
  - grants in T+1 to T+4;
  - DONE outputs in T+6.
REQ-030 Flush:
  - flush_i=1 in FETCH: go to IDLE next cycle; no cache write, no inst_valid_o;
  - the in-flight return byte is discarded;
  - flush_i has priority over fetch_req_i in IDLE;
  - flush_i in DONE does not suppress the outputs (cache fill remains valid; the consumer drops inst_valid_o).
REQ-031 rdy=0:
  - no register changes;
  - mem_req_o=0;
  - mem_gnt_i and mem_data_i are ignored;
  - outputs hold their values, except cache_we_o=0 and inst_valid_o=0.
REQ-032 Outside the specified cycles, these outputs are 0:
  - mem_req_o;
  - cache_we_o;
  - inst_valid_o.
REQ-033 pc alignment is not checked; a misaligned base fetches 4 consecutive bytes.

Reset
REQ-034 rst=0 asynchronously forces:
  - state=IDLE, counters=0, buffer=0, base=0;
  - all registered outputs = 0.
REQ-035 Reset mid-FETCH discards partial bytes; no cache write follows.
REQ-036 The first edge after rst returns to 1 behaves as IDLE.

Verification
REQ-037 Hit: pc_i=0x100, cache_hit_i=1, cache_inst_i=0x00000013 -> next cycle inst_valid_o=1, inst_o=0x13, inst_pc_o=0x100, mem_req_o stays 0.
REQ-038 Miss:
  - stimulus: pc_i=0x200, no hit, mem_gnt_i=1 always, bytes 0x93,0x00,0x10,0x00;
  - response: mem_addr_o 0x200..0x203 in T+1..T+4;
  - response in T+6: cache_we_o=1, cache_wpc_o=0x200, cache_winst_o=0x00100093, inst_valid_o=1.
REQ-039 Grant stalls: miss at 0x300 with mem_gnt_i=0 on 2 cycles -> addresses repeat until granted, DONE at T+8, data correct.
REQ-040 Flush: flush_i=1 after 2 bytes received -> IDLE next cycle, no cache_we_o, no inst_valid_o; a following hit at 0x400 is delivered normally.
REQ-041 rdy: rdy=0 for 3 cycles mid-miss -> no state change, mem_req_o=0; completion is delayed exactly 3 cycles with a correct word.
REQ-042 Reset: rst=0 mid-FETCH -> all outputs 0 immediately, state IDLE; no fill occurs after release.
